// File: rtl/mem_resp_pkg.sv
// Shared types, constants and the address-fault helper for the wait-state memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_resp_state_t;

    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
    localparam int unsigned WORD_BYTES = 32'd4;

    // A byte address faults when it is not word aligned or lies above the storage window.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned idx_bits);
        logic [31:0] ofs_s;
        logic [31:0] hi_s;
        ofs_s = addr & (WORD_BYTES - 32'd1);
        hi_s  = addr >> ($clog2(WORD_BYTES) + idx_bits);
        return (ofs_s != 32'd0) || (hi_s != 32'd0);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: synchronous write, combinational read.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait states and address fault reporting.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int    DEPTH       = 256,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    output logic        Err,
    output logic        Busy
);

    localparam int         OFS_BITS = $clog2(WORD_BYTES);
    localparam int         IDX_BITS = $clog2(DEPTH);
    localparam logic [3:0] CNT_LAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    mem_resp_state_t      state_r;
    mem_resp_state_t      state_s;
    logic [3:0]           cnt_r;
    logic [3:0]           cnt_s;
    logic                 enter_resp_s;
    logic                 accept_s;

    logic                 wr_r;
    logic [31:0]          addr_r;
    logic [31:0]          data_r;

    logic                 src_wr_s;
    logic [31:0]          src_addr_s;
    logic                 src_fault_s;
    logic                 cur_fault_s;
    logic [IDX_BITS-1:0]  rd_idx_s;
    logic [IDX_BITS-1:0]  wr_idx_s;
    logic                 we_s;
    logic [31:0]          rd_data_s;

    logic [31:0]          dout_r;
    logic                 ready_r;
    logic                 err_r;
    logic                 busy_r;

    // Response source: with no wait states RESP is entered on the accept edge, so the live inputs apply.
    always_comb begin
        accept_s = (state_r == IDLE) && Req;
        if (state_r == IDLE) begin
            src_wr_s   = Wr;
            src_addr_s = Address;
        end else begin
            src_wr_s   = wr_r;
            src_addr_s = addr_r;
        end
        src_fault_s = addr_fault(src_addr_s, IDX_BITS);
        cur_fault_s = addr_fault(addr_r, IDX_BITS);
        rd_idx_s    = src_addr_s[OFS_BITS +: IDX_BITS];
        wr_idx_s    = addr_r[OFS_BITS +: IDX_BITS];
        we_s        = (state_r == RESP) && wr_r && !cur_fault_s;
    end

    // Next-state and wait counter; the counter parks at its last value instead of wrapping.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (Req) begin
                    cnt_s = 4'd0;
                    if (WAIT_CYCLES > 0) begin
                        state_s = WAIT;
                    end else begin
                        state_s      = RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request capture on the accept edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_r   <= 1'b0;
            addr_r <= 32'd0;
            data_r <= 32'd0;
        end else if (accept_s) begin
            wr_r   <= Wr;
            addr_r <= Address;
            data_r <= DataIn;
        end
    end

    // Registered response outputs; DataOut only moves on read or fault responses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dout_r  <= 32'd0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ready_r <= enter_resp_s;
            err_r   <= enter_resp_s && src_fault_s;
            busy_r  <= (state_s != IDLE);
            if (enter_resp_s && src_fault_s) begin
                dout_r <= ERR_DATA;
            end else if (enter_resp_s && !src_wr_s) begin
                dout_r <= rd_data_s;
            end
        end
    end

    mem_resp_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .Clk   (Clk),
        .we    (we_s),
        .waddr (wr_idx_s),
        .wdata (data_r),
        .raddr (rd_idx_s),
        .rdata (rd_data_s)
    );

    assign DataOut = dout_r;
    assign Ready   = ready_r;
    assign Err     = err_r;
    assign Busy    = busy_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench driving two responders (2 and 0 wait states) with the same directed requests.
module tb_mem_responder;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] r;
    } vec_t;

    localparam int WT [2] = '{2, 0};

    localparam vec_t VECS [13] = '{
        '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0000_0000},
        '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678},
        '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000},
        '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678},
        '{1'b1, 32'h0000_03FC, 32'hCAFE_03FC, 1'b0, 32'h0000_0000},
        '{1'b1, 32'h0000_0000, 32'h0000_A5A5, 1'b0, 32'h0000_0000},
        '{1'b0, 32'h0000_0400, 32'h0000_0000, 1'b1, 32'h0000_0000},
        '{1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hCAFE_03FC},
        '{1'b1, 32'h0000_0400, 32'h1111_1111, 1'b1, 32'h0000_0000},
        '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_A5A5},
        '{1'b1, 32'h0000_0020, 32'h5555_0020, 1'b0, 32'h0000_0000},
        '{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h5555_0020},
        '{1'b0, 32'h8000_0010, 32'h0000_0000, 1'b1, 32'h0000_0000}
    };

    localparam logic [31:0] TP_A [8] = '{32'h10, 32'h3FC, 32'h20, 32'h0, 32'h3FC, 32'h10, 32'h0, 32'h20};
    localparam logic [31:0] TP_R [8] = '{32'h1234_5678, 32'hCAFE_03FC, 32'h5555_0020, 32'h0000_A5A5,
                                         32'hCAFE_03FC, 32'h1234_5678, 32'h0000_A5A5, 32'h5555_0020};

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout [2];
    logic [1:0]  rdy;
    logic [1:0]  err;
    logic [1:0]  busy;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          rcount [2] = '{0, 0};
    int          free [2] = '{0, 0};
    logic [31:0] last [2] = '{32'd0, 32'd0};
    exp_t        q0 [$];
    exp_t        q1 [$];

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .INIT_FILE("")) u_w2 (
        .Clk(clk), .Reset(rst_n), .Req(req), .Wr(wr), .Address(addr), .DataIn(din),
        .DataOut(dout[0]), .Ready(rdy[0]), .Err(err[0]), .Busy(busy[0])
    );

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .INIT_FILE("")) u_w0 (
        .Clk(clk), .Reset(rst_n), .Req(req), .Wr(wr), .Address(addr), .DataIn(din),
        .DataOut(dout[1]), .Ready(rdy[1]), .Err(err[1]), .Busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int c, input logic e, input logic [31:0] dt);
        exp_t x;
        x.cyc  = c;
        x.err  = e;
        x.data = dt;
        if (d == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_dout_dut%0d", tag, d), dout[d], 32'd0);
            chk($sformatf("%s_ready_dut%0d", tag, d), {31'd0, rdy[d]}, 32'd0);
            chk($sformatf("%s_err_dut%0d", tag, d), {31'd0, err[d]}, 32'd0);
            chk($sformatf("%s_busy_dut%0d", tag, d), {31'd0, busy[d]}, 32'd0);
        end
    endtask

    // Presents one request for exactly one edge; returns #1 after that edge.
    task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] dv);
        req  = 1'b1;
        wr   = w;
        addr = a;
        din  = dv;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        drive_req(v.w, v.a, v.d);
        for (int d = 0; d < 2; d++) begin
            if (v.e) last[d] = 32'hDEAD_BEEF;
            else if (!v.w) last[d] = v.r;
            push(d, cyc + WT[d], v.e, last[d]);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   qs;
        if (rdy[d]) begin
            rcount[d]++;
            qs = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_ready_dut%0d: got Ready=1 at cycle %0d, required no response", d, cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("ready_cycle_dut%0d", d), cyc, e.cyc);
                chk($sformatf("err_dut%0d", d), {31'd0, err[d]}, {31'd0, e.err});
                chk($sformatf("dataout_dut%0d", d), dout[d], e.data);
                chk($sformatf("busy_in_resp_dut%0d", d), {31'd0, busy[d]}, 32'd1);
            end
        end else if (err[d]) begin
            n_chk++;
            n_err++;
            $display("FAIL err_without_ready_dut%0d: got Err=1 Ready=0, required Err=0", d);
        end
    endtask

    // Monitor: compares every response against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon(0);
                mon(1);
            end
        end
    end

    initial begin
        int rc0;
        int rc1;
        int guard;
        rst_n = 1'b0;
        req   = 1'b0;
        wr    = 1'b0;
        addr  = 32'd0;
        din   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            issue(VECS[i]);
        end

        // Req held for 8 edges: only idle DUTs accept, each at its own period.
        rc0 = rcount[0];
        rc1 = rcount[1];
        free[0] = 0;
        free[1] = 0;
        req = 1'b1;
        wr  = 1'b0;
        din = 32'd0;
        for (int i = 0; i < 8; i++) begin
            addr = TP_A[i];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (cyc >= free[d]) begin
                    free[d] = cyc + WT[d] + 2;
                    last[d] = TP_R[i];
                    push(d, cyc + WT[d], 1'b0, TP_R[i]);
                end
            end
        end
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held_req_pulses_dut0", rcount[0] - rc0, 32'd2);
        chk("held_req_pulses_dut1", rcount[1] - rc1, 32'd4);

        // Reset while the write is in flight: it must vanish without a response.
        drive_req(1'b1, 32'h0000_0020, 32'hAAAA_AAAA);
        chk("busy_inflight_dut0", {31'd0, busy[0]}, 32'd1);
        chk("busy_inflight_dut1", {31'd0, busy[1]}, 32'd1);
        rst_n   = 1'b0;
        last[0] = 32'd0;
        last[1] = 32'd0;
        @(negedge clk);
        check_idle("midop_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue('{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h5555_0020});

        guard = 0;
        while (((q0.size() != 0) || (q1.size() != 0)) && (guard < 20)) begin
            @(posedge clk);
            guard++;
        end
        chk("pending_responses_dut0", q0.size(), 32'd0);
        chk("pending_responses_dut1", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
